quantoniumos_job_scheduler: RTL

//  Round-robin job scheduler in front of quantoniumos_unified_core; N requesters share one core.

---
 rtl/quantoniumos_sched_pkg.sv | 32 +++
 rtl/qos_rr_arbiter.sv | 36 +++
 rtl/quantoniumos_job_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/quantoniumos_sched_pkg.sv
// Shared types and widths for the QuantoniumOS job scheduler.
// Used by the round-robin arbiter and the scheduler top.
package quantoniumos_sched_pkg;

   localparam int MODE_W = 3;
   localparam int DATA_W = 128;
   localparam int KEY_W  = 256;
   localparam int OUT_W  = 256;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } sched_state_e;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_TIMEOUT  = 2'd1,
      ST_BAD_MODE = 2'd2
   } rsp_status_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/qos_rr_arbiter.sv
// Combinational round-robin arbiter: first request at/after the
// pointer (wrapping) wins; returns one-hot grant and winner index.
module qos_rr_arbiter
   import quantoniumos_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_idx
);

   logic [ID_W:0] w_sum;
   logic          w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         end
         if (!w_found && i_req[w_sum[ID_W-1:0]]) begin
            w_found                 = 1'b1;
            o_idx                   = w_sum[ID_W-1:0];
            o_gnt[w_sum[ID_W-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/quantoniumos_job_scheduler.sv
// Round-robin job scheduler sharing one unified core among NUM_REQ requesters.
// Optional saturating job statistics with QUANTONIUM_SCHED_STATS_EN.
module quantoniumos_job_scheduler
   import quantoniumos_sched_pkg::*;
#(
   parameter  int          NUM_REQ        = 4,
   parameter  int unsigned TIMEOUT_CYCLES = 200000,
   parameter  int          MAX_MODE       = 3,
   localparam int          ID_W           = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*MODE_W-1:0]   req_mode,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*KEY_W-1:0]    req_key,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [OUT_W-1:0]            rsp_data,
   output logic [1:0]                  rsp_status,
   output logic                        core_start,
   output logic [MODE_W-1:0]           core_mode,
   output logic [DATA_W-1:0]           core_data_in,
   output logic [KEY_W-1:0]            core_master_key,
   input  logic                        core_done,
   input  logic [OUT_W-1:0]            core_data_out,
   output logic                        busy
`ifdef QUANTONIUM_SCHED_STATS_EN
   ,
   output logic [31:0]                 stat_jobs_ok,
   output logic [15:0]                 stat_timeouts,
   output logic [15:0]                 stat_bad_mode
`endif
);

   localparam logic [31:0]       TO_LIM = TIMEOUT_CYCLES;
   localparam logic [MODE_W-1:0] MAX_M  = MODE_W'(MAX_MODE);

   sched_state_e        r_state;
   rsp_status_e         r_status;
   logic [NUM_REQ-1:0]  r_req_ready;
   logic [ID_W-1:0]     r_gidx;
   logic [ID_W-1:0]     r_rr;
   logic [31:0]         r_wdog;
   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [OUT_W-1:0]    r_rsp_data;
   logic                r_core_start;
   logic [MODE_W-1:0]   r_core_mode;
   logic [DATA_W-1:0]   r_core_data;
   logic [KEY_W-1:0]    r_core_key;

   logic [NUM_REQ-1:0]  w_gnt;
   logic [ID_W-1:0]     w_gidx;
   logic [MODE_W-1:0]   w_mode;
   logic [DATA_W-1:0]   w_data;
   logic [KEY_W-1:0]    w_key;
   logic                w_accept;
   logic [ID_W-1:0]     w_rr_nxt;
   logic [31:0]         w_wdog_nxt;
   logic                w_rsp_hs;

   qos_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req (req_valid),
      .i_ptr (r_rr),
      .o_gnt (w_gnt),
      .o_idx (w_gidx)
   );

   // Payload mux keyed by the index granted in the previous (IDLE) cycle
   always_comb begin
      w_mode = '0;
      w_data = '0;
      w_key  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gidx == ID_W'(i)) begin
            w_mode = req_mode[i*MODE_W +: MODE_W];
            w_data = req_data[i*DATA_W +: DATA_W];
            w_key  = req_key[i*KEY_W +: KEY_W];
         end
      end
   end

   assign w_accept   = |(req_valid & r_req_ready);
   assign w_rr_nxt   = (r_gidx == ID_W'(NUM_REQ-1)) ? '0 : r_gidx + ID_W'(1);
   assign w_wdog_nxt = sat_inc32(r_wdog);
   assign w_rsp_hs   = r_rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_status     <= ST_OK;
         r_req_ready  <= '0;
         r_gidx       <= '0;
         r_rr         <= '0;
         r_wdog       <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_data   <= '0;
         r_core_start <= 1'b0;
         r_core_mode  <= '0;
         r_core_data  <= '0;
         r_core_key   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (|req_valid) begin
                  r_req_ready <= w_gnt;
                  r_gidx      <= w_gidx;
                  r_state     <= S_GRANT;
               end
            end
            S_GRANT: begin
               r_req_ready <= '0;
               if (!w_accept) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rr     <= w_rr_nxt;
                  r_rsp_id <= r_gidx;
                  if (w_mode > MAX_M) begin
                     r_status    <= ST_BAD_MODE;
                     r_rsp_data  <= '0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     r_core_mode  <= w_mode;
                     r_core_data  <= w_data;
                     r_core_key   <= w_key;
                     r_core_start <= 1'b1;
                     r_state      <= S_START;
                  end
               end
            end
            S_START: begin
               r_core_start <= 1'b0;
               r_wdog       <= '0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               r_wdog <= w_wdog_nxt;
               // A done arriving on the timeout cycle still counts as success
               if (core_done) begin
                  r_status    <= ST_OK;
                  r_rsp_data  <= core_data_out;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (w_wdog_nxt >= TO_LIM) begin
                  r_status    <= ST_TIMEOUT;
                  r_rsp_data  <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready       = r_req_ready;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_id          = r_rsp_id;
   assign rsp_data        = r_rsp_data;
   assign rsp_status      = r_status;
   assign core_start      = r_core_start;
   assign core_mode       = r_core_mode;
   assign core_data_in    = r_core_data;
   assign core_master_key = r_core_key;
   assign busy            = (r_state != S_IDLE);

`ifdef QUANTONIUM_SCHED_STATS_EN
   logic [31:0] r_stat_ok;
   logic [15:0] r_stat_to;
   logic [15:0] r_stat_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stat_ok  <= '0;
         r_stat_to  <= '0;
         r_stat_bad <= '0;
      end else if (w_rsp_hs) begin
         unique case (1'b1)
            (r_status == ST_OK):       r_stat_ok  <= sat_inc32(r_stat_ok);
            (r_status == ST_TIMEOUT):  r_stat_to  <= sat_inc16(r_stat_to);
            (r_status == ST_BAD_MODE): r_stat_bad <= sat_inc16(r_stat_bad);
            default: ;
         endcase
      end
   end

   assign stat_jobs_ok  = r_stat_ok;
   assign stat_timeouts = r_stat_to;
   assign stat_bad_mode = r_stat_bad;
`else
   logic w_unused_hs;
   assign w_unused_hs = w_rsp_hs;
`endif

endmodule
